// File: rtl/exe_muldiv_pkg.sv
// exe_muldiv_pkg: shared constants and types for the RV32M execute unit.
// Instruction field codes, funct3 encodings and the FSM state type live here
// so the top, the divider core and the bench agree on one definition.
package exe_muldiv_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M      = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Remainder ops take the sign of the dividend instead of s1^s2.
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

endpackage

// File: rtl/exe_div_core.sv
// exe_div_core: unsigned restoring divider, one quotient bit per step.
// start_i loads the operands, step_i advances one iteration, clear_i aborts.
// quotient_o/remainder_o are final once last_o has been seen and hold until
// the next start or clear.
module exe_div_core
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;
  logic          fits;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, div_q};
  assign fits      = ~diff[XLEN];

  // Next-state: load on start, one restoring step per step_i, clear wins.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      div_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (fits) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clear_i) begin
      rem_d = '0;
      quo_d = '0;
      div_d = '0;
      cnt_d = '0;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o      = step_i && (cnt_q == CNT_LAST);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: RV32M execute unit (MUL*/DIV*/REM*).
// Operands are converted to magnitudes at start, an unsigned multiply or
// divide runs on them, and the sign is reapplied in the single DONE cycle.
// Divide-by-zero and signed overflow bypass the divider and finish in one
// stall cycle. Build option MULDIV_FAST_MUL_EN replaces the 32-cycle
// shift-add multiplier with a single-cycle 33x33 signed multiplier.
// Handshake: stall_req_o is high from the start cycle until the cycle before
// DONE; valid_o is a one-cycle strobe in DONE and all result outputs are
// zero whenever valid_o is low. flush_i drops everything in the same cycle.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [XLEN-1:0]        op1_i,
  input  logic [XLEN-1:0]        op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   flush_i,
  output logic                   stall_req_o,
  output logic                   valid_o,
  output logic [XLEN-1:0]        reg_wdata_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output md_state_e              dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // Instruction decode.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_m;
  logic       start;
  logic       unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign funct7      = inst_i[31:25];
  assign is_m        = (opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_M);
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

  // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both.
  logic            op1_signed, op2_signed, s1, s2;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign op1_signed = (funct3 == INST_MULH) || (funct3 == INST_MULHSU) ||
                      (funct3 == INST_DIV)  || (funct3 == INST_REM);
  assign op2_signed = (funct3 == INST_MULH) || (funct3 == INST_DIV) ||
                      (funct3 == INST_REM);
  assign s1   = op1_signed & op1_i[XLEN-1];
  assign s2   = op2_signed & op2_i[XLEN-1];
  assign abs1 = s1 ? (~op1_i + 1'b1) : op1_i;
  assign abs2 = s2 ? (~op2_i + 1'b1) : op2_i;

  assign div_zero = funct3[2] && (op2_i == '0);
  assign div_ovf  = ((funct3 == INST_DIV) || (funct3 == INST_REM)) &&
                    (op1_i == INT_MIN) && (op2_i == '1);
  assign special  = div_zero || div_ovf;

  // Results that skip the divider entirely.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? op1_i : DIV_BY_ZERO_Q[XLEN-1:0];
    end else if (div_ovf) begin
      special_res = funct3[1] ? '0 : INT_MIN;
    end
  end

  // Registered state.
  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;

  // Divider datapath.
  logic            div_start, div_step, div_last;
  logic [XLEN-1:0] div_quo, div_rem;

  assign start     = (state_q == MD_IDLE) && is_m && !flush_i;
  assign div_start = start && funct3[2] && !special;
  assign div_step  = (state_q == MD_DIV) && !flush_i;

  exe_div_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .start_i     (div_start),
    .step_i      (div_step),
    .dividend_i  (abs1),
    .divisor_i   (abs2),
    .last_o      (div_last),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (acc_q[0]) is set, then shift right by one.
  logic [XLEN-1:0] mul_add;
  logic [XLEN:0]   mul_sum;

  assign mul_add = acc_q[0] ? mcand_q : '0;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  assign fast_prod = $signed({1'b0, abs1}) * $signed({1'b0, abs2});
`endif

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (!funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            state_d = MD_DONE;
`else
            state_d = MD_MUL;
`endif
          end else if (special) begin
            state_d = MD_DONE;
          end else begin
            state_d = MD_DIV;
          end
        end
      end
      MD_MUL:  if (cnt_q == CNT_LAST) state_d = MD_DONE;
      MD_DIV:  if (div_last) state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  // Operand/context latching at start and the multiplier iteration.
  always_comb begin
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    neg_d      = neg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    if (start) begin
      f3_d       = funct3;
      we_d       = reg_we_i;
      waddr_d    = reg_waddr_i;
      neg_d      = is_rem(funct3) ? s1 : (s1 ^ s2);
      special_d  = special;
      spec_res_d = special_res;
      mcand_d    = abs1;
      acc_d      = {{XLEN{1'b0}}, abs2};
      cnt_d      = '0;
`ifdef MULDIV_FAST_MUL_EN
      if (!funct3[2]) acc_d = fast_prod[2*XLEN-1:0];
`endif
    end else if (state_q == MD_MUL) begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_q == MD_DONE) || flush_i) cnt_d = '0;
  end

  // State and context registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      neg_q      <= neg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
    end
  end

  // Sign correction and result selection for the DONE cycle.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result;

  always_comb begin
    prod   = neg_q ? (~acc_q + 1'b1) : acc_q;
    result = '0;
    case (f3_q)
      INST_MUL:                          result = prod[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: result = prod[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:               result = neg_q ? (~div_quo + 1'b1) : div_quo;
      default:                           result = neg_q ? (~div_rem + 1'b1) : div_rem;
    endcase
    if (special_q) result = spec_res_q;
  end

  // Outputs: stall while working, one-cycle writeback in DONE.
  always_comb begin
    stall_req_o = !flush_i && (start || (state_q == MD_MUL) || (state_q == MD_DIV));
    valid_o     = (state_q == MD_DONE) && !flush_i;
    reg_we_o    = valid_o & we_q;
    reg_waddr_o = valid_o ? waddr_q : '0;
    reg_wdata_o = valid_o ? result : '0;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed bench for exe_muldiv with a behavioural RV32M model.
// Define MULDIV_FAST_MUL_EN for both bench and RTL to check the fast build.
module tb_exe_muldiv;
  import exe_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] op1, op2;
  logic        reg_we;
  logic [4:0]  waddr;
  logic        flush;
  logic        stall_req, valid;
  logic [31:0] wdata;
  logic        we_o;
  logic [4:0]  waddr_o;
  md_state_e   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] exp_q[$];
  logic [37:0] cmp_e;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        chk;
    logic [31:0] lit;
  } vec_t;
  vec_t vecs[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALLS = 1;
  localparam logic [2:0] RST_OP = INST_DIVU;
`else
  localparam int MUL_STALLS = 33;
  localparam logic [2:0] RST_OP = INST_MUL;
`endif

  exe_muldiv dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .inst_i      (inst),
    .op1_i       (op1),
    .op2_i       (op2),
    .reg_we_i    (reg_we),
    .reg_waddr_i (waddr),
    .flush_i     (flush),
    .stall_req_o (stall_req),
    .valid_o     (valid),
    .reg_wdata_o (wdata),
    .reg_we_o    (we_o),
    .reg_waddr_o (waddr_o),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] make_inst(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // Behavioural RV32M reference using plain signed/unsigned arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pu;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    pu  = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return MUL_STALLS;
    if (b == 0) return 1;
    if ((f3 == INST_DIV || f3 == INST_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Scoreboard: every writeback must match the next queued expectation,
  // and result outputs must read zero on every other cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {we_o, waddr_o, wdata}, 38'h0);
        end else begin
          cmp_e = exp_q.pop_front();
          check("writeback", {26'h0, we_o, waddr_o, wdata}, {26'h0, cmp_e});
        end
      end else begin
        check("idle_outputs", {we_o, waddr_o, wdata}, 38'h0);
      end
    end
  end

  // Issue one M instruction, hold it like id_exe would until DONE, then
  // replace it with an ADD and confirm it neither stalls nor retriggers.
  task automatic run_op(input vec_t v);
    int stalls;
    bit got;
    @(posedge clk); #1;
    inst   = make_inst(FUNCT7_M, v.f3, v.rd, INST_TYPE_R_M);
    op1    = v.a;
    op2    = v.b;
    reg_we = v.we;
    waddr  = v.rd;
    exp_q.push_back({v.we, v.rd, model(v.f3, v.a, v.b)});
    stalls = 0;
    got    = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (valid) begin
        got = 1;
        if (v.chk) check("literal_result", wdata, v.lit);
      end else if (stall_req) begin
        stalls++;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: got no valid_o, required one for funct3=%0d", v.f3);
      void'(exp_q.pop_back());
    end
    check("stall_cycles", stalls, exp_stalls(v.f3, v.a, v.b));
    @(posedge clk); #1;
    inst = make_inst(7'b0, 3'b000, 5'd3, INST_TYPE_R_M);
    @(negedge clk);
    check("no_retrigger_stall", stall_req, 1'b0);
    check("single_valid", valid, 1'b0);
  endtask

  task automatic add_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we, input logic chk,
                         input logic [31:0] lit);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.we = we; v.chk = chk; v.lit = lit;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    rst    = 1'b1;
    flush  = 1'b0;
    inst   = '0;
    op1    = '0;
    op2    = '0;
    reg_we = 1'b0;
    waddr  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", dbg_state, MD_IDLE);
    check("reset_stall", stall_req, 1'b0);
    check("reset_valid", valid, 1'b0);

    // Non-M instructions on the R opcode and an M funct7 on another opcode.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0: inst = make_inst(7'b0000000, 3'b000, 5'd4, INST_TYPE_R_M);
        1: inst = make_inst(7'b0100000, 3'b000, 5'd4, INST_TYPE_R_M);
        default: inst = make_inst(FUNCT7_M, 3'b100, 5'd4, 7'b0010011);
      endcase
      @(negedge clk);
      check("non_m_stall", stall_req, 1'b0);
      check("non_m_state", dbg_state, MD_IDLE);
    end

    // Directed vectors with hand-computed results.
    add_vec(INST_DIV,    32'hFFFF_FFEC, 32'd3,         5'd5,  1'b1, 1'b1, 32'hFFFF_FFFA);
    add_vec(INST_REM,    32'hFFFF_FFEC, 32'd3,         5'd6,  1'b1, 1'b1, 32'hFFFF_FFFE);
    add_vec(INST_DIVU,   32'd100,       32'd0,         5'd7,  1'b1, 1'b1, 32'hFFFF_FFFF);
    add_vec(INST_REMU,   32'd100,       32'd0,         5'd8,  1'b1, 1'b1, 32'd100);
    add_vec(INST_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  1'b1, 1'b1, 32'h8000_0000);
    add_vec(INST_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b1, 32'h0);
    add_vec(INST_MULH,   32'h8000_0000, 32'h8000_0000, 5'd11, 1'b1, 1'b1, 32'h4000_0000);
    add_vec(INST_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b1, 32'hFFFF_FFFF);
    add_vec(INST_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b1, 32'hFFFF_FFFE);
    add_vec(INST_MUL,    32'd7,         32'd6,         5'd0,  1'b1, 1'b1, 32'd42);
    add_vec(INST_DIV,    32'd7,         32'd0,         5'd14, 1'b0, 1'b1, 32'hFFFF_FFFF);
    add_vec(INST_REM,    32'hFFFF_FFF9, 32'd0,         5'd15, 1'b1, 1'b1, 32'hFFFF_FFF9);
    add_vec(INST_MUL,    32'hFFFF_FFFD, 32'd5,         5'd16, 1'b1, 1'b1, 32'hFFFF_FFF1);
    add_vec(INST_MULH,   32'hFFFF_FFFD, 32'd5,         5'd17, 1'b1, 1'b1, 32'hFFFF_FFFF);
    add_vec(INST_DIVU,   32'hFFFF_FFFF, 32'd2,         5'd18, 1'b1, 1'b1, 32'h7FFF_FFFF);
    add_vec(INST_REMU,   32'hFFFF_FFFF, 32'd2,         5'd19, 1'b1, 1'b1, 32'd1);
    add_vec(INST_DIV,    32'd7,         32'hFFFF_FFFE, 5'd20, 1'b1, 1'b1, 32'hFFFF_FFFD);
    add_vec(INST_REM,    32'd7,         32'hFFFF_FFFE, 5'd21, 1'b1, 1'b1, 32'd1);
    // Model-only vectors over all eight ops with arbitrary operands.
    for (int i = 0; i < 8; i++) begin
      add_vec(3'(i), $urandom(), $urandom_range(1, 32'h7FFF_FFFF) | (32'(i & 1) << 31),
              5'(i + 22), 1'b1, 1'b0, 32'h0);
    end
    foreach (vecs[i]) run_op(vecs[i]);

    // Flush at iteration 10 of a DIV.
    @(posedge clk); #1;
    inst = make_inst(FUNCT7_M, INST_DIV, 5'd5, INST_TYPE_R_M);
    op1  = 32'd1000;
    op2  = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", stall_req, 1'b0);
    check("flush_valid", valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    inst  = '0;
    @(negedge clk);
    check("flush_state", dbg_state, MD_IDLE);
    check("flush_after_stall", stall_req, 1'b0);
    v.f3 = INST_MUL; v.a = 32'd12; v.b = 32'd11; v.rd = 5'd3; v.we = 1'b1;
    v.chk = 1'b1; v.lit = 32'd132;
    run_op(v);

    // Reset mid-operation at iteration 5.
    @(posedge clk); #1;
    inst = make_inst(FUNCT7_M, RST_OP, 5'd9, INST_TYPE_R_M);
    op1  = 32'd1234;
    op2  = 32'd5;
    reg_we = 1'b1;
    waddr  = 5'd9;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    inst = '0;
    @(negedge clk);
    check("rst_state", dbg_state, MD_IDLE);
    check("rst_outputs", {stall_req, valid, we_o, waddr_o, wdata}, 40'h0);
    v.f3 = INST_MUL; v.a = 32'd7; v.b = 32'd6; v.rd = 5'd4; v.we = 1'b1;
    v.chk = 1'b1; v.lit = 32'd42;
    run_op(v);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Execute-stage unit for RV32M; consumes the decode outputs latched by id_exe (inst, op1, op2, reg_we, reg_waddr).
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with iterative shift-add / restoring-division datapaths.
- Holds the pipeline via stall_req_o while busy. Presents a one-cycle writeback result to exe_mem and to the id forwarding path.

Parameters:
- XLEN, 32, operand/result width; equals `RDATA_WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- inst_i  input  `DATA_WIDTH  instruction from id_exe
- op1_i  input  XLEN  rs1 operand (already forwarded)
- op2_i  input  XLEN  rs2 operand (already forwarded)
- reg_we_i  input  1  write enable from id_exe
- reg_waddr_i  input  `RADDR_WIDTH  destination register from id_exe
- flush_i  input  1  pipeline flush; aborts an operation in progress
- stall_req_o  output  1  hold id_exe/if_id/pc
- valid_o  output  1  result strobe, one cycle
- reg_wdata_o  output  XLEN  result
- reg_we_o  output  1  result write enable
- reg_waddr_o  output  `RADDR_WIDTH  result destination

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset: state=IDLE; all outputs 0; internal registers 0.
- Start condition: state==IDLE, opcode==`INST_TYPE_R_M, funct7==7'b0000001, flush_i==0.
- In IDLE, stall_req_o is asserted combinationally in the start cycle.
- At the start edge, latch the following:
  - funct3, reg_we_i, reg_waddr_i.
  - |op1|, |op2|, with magnitude taken only for signed operand positions: MULH both, MULHSU op1 only, DIV/REM both.
  - Result sign: product = s1^s2; quotient = s1^s2; remainder = s1.
- States: IDLE, MUL, DIV, DONE.
- IDLE to MUL: start with funct3[2]==0.
- IDLE to DIV: start with funct3[2]==1 and the divisor is neither 0 nor overflow.
- IDLE to DONE: start with a special case. Each special case costs exactly 1 stall cycle.
  - Divide by zero: DIV/DIVU result 32'hFFFF_FFFF; REM/REMU result = op1_i.
  - Overflow: DIV with op1=32'h8000_0000 and op2=32'hFFFF_FFFF gives 32'h8000_0000; REM in the same case gives 0.
- MUL: 32 iterations of shift-add into a 64-bit accumulator; counter counts 0..31; on count 31 go to DONE.
- DIV: 32 iterations of restoring division, one quotient bit per cycle; on count 31 go to DONE.
- Latency: start cycle + 32 iteration cycles. DONE is the 34th cycle counting the start cycle. stall_req_o is high for 33 cycles and low in DONE.
- DONE, single cycle:
  - valid_o=1, reg_we_o=latched we, reg_waddr_o=latched rd.
  - reg_wdata_o is selected by funct3: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits of the sign-corrected 64-bit product.
  - DIV/DIVU: quotient. REM/REMU: remainder. Each is two's-complement negated when its sign flag is set.
  - Next state IDLE. The id_exe instruction still visible during DONE must not retrigger, because the start condition requires IDLE.
- Outside DONE: valid_o, reg_we_o, reg_wdata_o and reg_waddr_o are all 0.
- flush_i=1 in any state: next state IDLE, counter cleared, no valid_o issued. stall_req_o is forced 0 in that cycle.
- rst_i has priority over flush_i. rst_i mid-operation returns to IDLE, identical to the power-on reset values.
- Non-M instructions: ignored; state and outputs unaffected.
- rd==x0: computed normally; reg_we_o passes through. The x0 write is discarded by regfile, and forwarding is masked by id.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: multiply uses a single-cycle 33x33 signed combinational multiplier. IDLE goes directly to DONE, 1 stall cycle; the MUL state is unused.
- MULDIV_FAST_MUL_EN undefined: iterative 32-cycle multiply as specified above.
- Division is identical in both builds.

Decomposition:
- Additions to defines.v:
  - `FUNCT7_M 7'b0000001
  - funct3 codes `INST_MUL..`INST_REMU
  - state encodings `MD_IDLE/`MD_MUL/`MD_DIV/`MD_DONE
  - `DIV_BY_ZERO_Q 32'hFFFF_FFFF
- Sub-module exe_div_core: restoring divider datapath (remainder/quotient shift registers, subtract-compare, counter).
- exe_muldiv keeps the FSM, the sign handling and the multiplier.

Test Plan:
- DIV op1=-20 (FFFF_FFEC), op2=3: stall 33 cycles, then valid_o=1 with reg_wdata_o=FFFF_FFFA (-6); REM of the same operands gives FFFF_FFFE (-2).
- DIVU op1=100, op2=0: 1 stall cycle, reg_wdata_o=FFFF_FFFF. REMU with the same operands gives 100. DIV 8000_0000 / FFFF_FFFF gives 8000_0000, 1 stall cycle.
- MULH op1=8000_0000, op2=8000_0000: reg_wdata_o=4000_0000. MULHSU op1=FFFF_FFFF, op2=FFFF_FFFF gives FFFF_FFFF. MULHU of the same operands gives FFFF_FFFE. Run iterative and MULDIV_FAST_MUL_EN builds (33 vs 1 stall).
- Back-to-back DIV then ADD held by id_exe stall: exactly one valid_o; no retrigger in DONE; ADD proceeds the cycle after DONE.
- flush_i at iteration 10 of DIV: state IDLE next cycle, stall_req_o=0, no valid_o; a new MUL starts cleanly afterwards.
- rst_i asserted mid-MUL at iteration 5: next cycle all outputs 0, state IDLE; a subsequent MUL 7*6 gives 42.
